// File: rtl/snn_pkg.sv
// Shared SNN definitions: decoder FSM encoding and default network dimensions,
// also used by the network core and the SPI readback logic.
package snn_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StArgmax = 2'd2,
        StDone   = 2'd3
    } snn_state_e;

    localparam int unsigned SNN_NUM_CLASSES = 5;
    localparam int unsigned SNN_CNT_W       = 8;
    localparam int unsigned SNN_WINDOW_LEN  = 100;

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of saturating per-class spike counters with a synchronous clear, a per-class
// increment vector and a combinational indexed read port.
module spike_counter_bank #(
    parameter int unsigned NUM_CLASSES = 5,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDX_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   inc_en,
    input  logic [NUM_CLASSES-1:0] inc,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [CNT_W-1:0]       rd_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (clear) begin
                    cnt_q[i] <= '0;
                end else if (inc_en && inc[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (IDX_W'(i) == rd_idx) rd_data = cnt_q[i];
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts output-layer spikes per class over a fixed window, then scans the counters one
// class per cycle to pick the winner (ties go to the lowest index) and pulses out_valid.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = SNN_NUM_CLASSES,
    parameter int unsigned CNT_W       = SNN_CNT_W,
    parameter int unsigned WINDOW_LEN  = SNN_WINDOW_LEN,
    parameter int unsigned IDX_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   spike_en,
    input  logic [NUM_CLASSES-1:0] spike_in,
    output logic                   busy,
    output logic                   out_valid,
    output logic [IDX_W-1:0]       class_id,
    output logic [CNT_W-1:0]       class_count,
    output logic                   no_spike
);

    localparam int unsigned WIN_W = $clog2(WINDOW_LEN + 1);

    snn_state_e       state_q, state_d;
    logic [WIN_W-1:0] win_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [CNT_W-1:0] rd_data;
    logic             last_win, last_idx, accepted;

    assign last_win = (win_q == WIN_W'(WINDOW_LEN - 1));
    assign last_idx = (idx_q == IDX_W'(NUM_CLASSES - 1));
    assign accepted = (state_q == StIdle) && start && !abort;

    spike_counter_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .clear   (accepted),
        .inc_en  ((state_q == StAccum) && spike_en && !abort),
        .inc     (spike_in),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start)    state_d = StAccum;
            StAccum:  if (last_win) state_d = StArgmax;
            StArgmax: if (last_idx) state_d = StDone;
            StDone:                 state_d = StIdle;
            default:                state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_comb begin
        busy      = (state_q == StAccum) || (state_q == StArgmax);
        out_valid = (state_q == StDone);
    end

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        if (rd_data > best_cnt_q) begin
            best_cnt_d = rd_data;
            best_idx_d = idx_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q       <= '0;
            idx_q       <= '0;
            best_cnt_q  <= '0;
            best_idx_q  <= '0;
            class_id    <= '0;
            class_count <= '0;
            no_spike    <= 1'b0;
        end else begin
            if (accepted) win_q <= '0;
            else if (state_q == StAccum) win_q <= win_q + 1'b1;

            if (state_q == StAccum) begin
                idx_q      <= '0;
                best_cnt_q <= '0;
                best_idx_q <= '0;
            end else if (state_q == StArgmax) begin
                idx_q      <= idx_q + 1'b1;
                best_cnt_q <= best_cnt_d;
                best_idx_q <= best_idx_d;
            end

            // Result lands on the edge into DONE so it is stable while out_valid is high.
            if ((state_q == StArgmax) && last_idx && !abort) begin
                class_id    <= best_idx_d;
                class_count <= best_cnt_d;
                no_spike    <= (best_cnt_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomised and directed bench for spike_rate_decoder; two instances cover the
// 100-cycle and 300-cycle windows, checked against a per-window count/argmax model.
module tb_spike_rate_decoder;

    localparam int NC = 5;

    logic          clk, reset, start_s, start_b, abort, spike_en;
    logic [NC-1:0] spike_in;
    logic          busy_s, ov_s, ns_s, busy_b, ov_b, ns_b;
    logic [2:0]    id_s, id_b;
    logic [7:0]    cc_s, cc_b;

    logic [NC-1:0] pat [300];
    bit            en  [300];
    int            exp_id [2];
    int            exp_cc [2];
    int            exp_ns [2];
    int            errors = 0;
    int            checks = 0;

    spike_rate_decoder #(.NUM_CLASSES(5), .CNT_W(8), .WINDOW_LEN(100), .IDX_W(3)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort), .spike_en(spike_en),
        .spike_in(spike_in), .busy(busy_s), .out_valid(ov_s), .class_id(id_s),
        .class_count(cc_s), .no_spike(ns_s)
    );

    spike_rate_decoder #(.NUM_CLASSES(5), .CNT_W(8), .WINDOW_LEN(300), .IDX_W(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort), .spike_en(spike_en),
        .spike_in(spike_in), .busy(busy_b), .out_valid(ov_b), .class_id(id_b),
        .class_count(cc_b), .no_spike(ns_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_pat();
        for (int k = 0; k < 300; k++) begin
            pat[k] = '0;
            en[k]  = 1'b0;
        end
    endtask

    // dens: per-bit spike probability in sixteenths; en_pct: spike_en duty in percent.
    task automatic fill_random(input int wlen, input int dens, input int en_pct);
        clear_pat();
        for (int k = 0; k < wlen; k++) begin
            for (int i = 0; i < NC; i++) pat[k][i] = ($urandom_range(15, 0) < dens);
            en[k] = ($urandom_range(99, 0) < en_pct);
        end
    endtask

    // sel: 0 = 100-cycle instance, 1 = 300-cycle instance.
    task automatic run_window(input int sel, input int pulse_at, input int abort_at,
                              input string tag);
        int wlen, best, bi, seen, lat, pulses, id_at, cc_at, ns_at;
        int cnt [NC];
        logic ov, bz;
        wlen = (sel == 1) ? 300 : 100;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        for (int k = 0; k < wlen; k++)
            for (int i = 0; i < NC; i++)
                if (en[k] && pat[k][i] && cnt[i] < 255) cnt[i]++;
        best = 0; bi = 0;
        for (int i = 0; i < NC; i++) if (cnt[i] > best) begin best = cnt[i]; bi = i; end
        seen = 0; lat = 0; pulses = 0; id_at = 0; cc_at = 0; ns_at = 0;

        @(negedge clk);
        if (sel == 1) start_b = 1'b1; else start_s = 1'b1;
        for (int k = 1; k <= wlen + NC + 7; k++) begin
            @(negedge clk);
            ov = (sel == 1) ? ov_b : ov_s;
            bz = (sel == 1) ? busy_b : busy_s;
            if (ov) begin
                pulses++;
                if (seen == 0) begin
                    seen  = 1;
                    lat   = k;
                    id_at = (sel == 1) ? id_b : id_s;
                    cc_at = (sel == 1) ? cc_b : cc_s;
                    ns_at = (sel == 1) ? ns_b : ns_s;
                end
            end
            if (k == 1 && abort_at != 1) check({tag, "/busy_accum"}, bz, 1);
            if (abort_at > 0 && k == abort_at + 1) check({tag, "/busy_after_abort"}, bz, 0);
            start_s = 1'b0; start_b = 1'b0; abort = 1'b0;
            if (k == pulse_at) begin
                if (sel == 1) start_b = 1'b1; else start_s = 1'b1;
            end
            if (k == abort_at) abort = 1'b1;
            if (k <= wlen) begin
                spike_en = en[k-1];
                spike_in = pat[k-1];
            end else begin
                spike_en = 1'b1;
                spike_in = NC'($urandom);
            end
        end
        spike_en = 1'b0; spike_in = '0;

        if (abort_at > 0) begin
            check({tag, "/no_valid"}, pulses, 0);
            check({tag, "/id_held"}, (sel == 1) ? id_b : id_s, exp_id[sel]);
            check({tag, "/count_held"}, (sel == 1) ? cc_b : cc_s, exp_cc[sel]);
            check({tag, "/no_spike_held"}, (sel == 1) ? ns_b : ns_s, exp_ns[sel]);
        end else begin
            check({tag, "/latency"}, lat, wlen + NC + 1);
            check({tag, "/pulses"}, pulses, 1);
            check({tag, "/class_id"}, id_at, bi);
            check({tag, "/class_count"}, cc_at, best);
            check({tag, "/no_spike"}, ns_at, (best == 0) ? 1 : 0);
            check({tag, "/id_hold"}, (sel == 1) ? id_b : id_s, bi);
            exp_id[sel] = bi;
            exp_cc[sel] = best;
            exp_ns[sel] = (best == 0) ? 1 : 0;
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; start_s = 1'b0; start_b = 1'b0; abort = 1'b0;
        spike_en = 1'b0; spike_in = '0;
        for (int s = 0; s < 2; s++) begin exp_id[s] = 0; exp_cc[s] = 0; exp_ns[s] = 0; end
        #1;
        check("reset/busy", busy_s, 0);
        check("reset/out_valid", ov_s, 0);
        check("reset/class_id", id_s, 0);
        check("reset/class_count", cc_s, 0);
        check("reset/no_spike", ns_s, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single winner: 30 spikes on class 2, 10 on class 0.
        clear_pat();
        for (int k = 0; k < 100; k++) en[k] = 1'b1;
        for (int k = 0; k < 30; k++) pat[k] = 5'b00100;
        for (int k = 30; k < 40; k++) pat[k] = 5'b00001;
        run_window(0, 0, 0, "winner");

        // Gated: spikes present but spike_en low for the whole window.
        clear_pat();
        for (int k = 0; k < 100; k++) pat[k] = 5'b11111;
        run_window(0, 0, 0, "gated");

        // Saturation on the 300-cycle instance.
        clear_pat();
        for (int k = 0; k < 300; k++) begin pat[k] = 5'b10000; en[k] = 1'b1; end
        run_window(1, 0, 0, "saturate");

        // Tie between classes 1 and 3.
        clear_pat();
        for (int k = 0; k < 100; k++) en[k] = 1'b1;
        for (int k = 10; k < 22; k++) pat[k] = 5'b01010;
        run_window(0, 0, 0, "tie");

        fill_random(100, 6, 90);
        run_window(0, 0, 51, "abort");
        fill_random(100, 4, 80);
        run_window(0, 0, 0, "fresh_after_abort");
        fill_random(100, 4, 80);
        run_window(0, 40, 0, "start_ignored");

        for (int r = 0; r < 4; r++) begin
            fill_random(100, $urandom_range(8, 1), $urandom_range(100, 50));
            run_window(0, 0, 0, $sformatf("random%0d", r));
        end
        fill_random(300, 15, 95);
        run_window(1, 0, 0, "dense_big");

        // Asynchronous reset in the middle of an accumulation window.
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0; spike_en = 1'b1; spike_in = 5'b11111;
        repeat (29) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset/busy", busy_s, 0);
        check("midreset/out_valid", ov_s, 0);
        check("midreset/class_id", id_s, 0);
        check("midreset/class_count", cc_s, 0);
        check("midreset/big_class_count", cc_b, 0);
        @(negedge clk);
        reset = 1'b1; spike_en = 1'b0; spike_in = '0;
        for (int s = 0; s < 2; s++) begin exp_id[s] = 0; exp_cc[s] = 0; exp_ns[s] = 0; end
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (ov_s) n++;
        end
        check("midreset/no_valid_after", n, 0);

        fill_random(100, 5, 90);
        run_window(0, 0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
